// File: rtl/data_mem_ls.sv
// Byte-addressable RV32 data memory: LB/LH/LW/LBU/LHU/SB/SH/SW, req/ready handshake, registered response.
// `DMEM_MISALIGN_SPLIT_EN: misaligned accesses are served; word-crossing ones take an extra SPLIT cycle.
`timescale 1ns/1ps
module data_mem_ls #(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [2:0]  size,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        resp_valid,
    output logic [31:0] rdata,
    output logic        err
);
    localparam int unsigned AW   = $clog2(DEPTH);
    localparam logic [32:0] SPAN = 33'(DEPTH) << 2;

    typedef enum logic {IDLE, SPLIT} state_t;

    logic [31:0]   mem [DEPTH];

    state_t        state_q, state_d;
    logic          resp_valid_q, resp_valid_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic [31:0]   offset;
    logic [1:0]    lane;
    logic [4:0]    shamt;
    logic [AW-1:0] word_idx;
    logic [2:0]    nbytes;
    logic [3:0]    mask;
    logic [32:0]   last_byte;
    logic          size_bad, store_bad, range_bad, align_bad, acc_err, accept;
    logic [3:0]    strb_lo;
    logic [31:0]   wd_lo;
    logic [31:0]   rd_word;

`ifdef DMEM_MISALIGN_SPLIT_EN
    logic          cross;
    logic [7:0]    strb8;
    logic [63:0]   wd64;
    logic [AW-1:0] sp_idx_q;
    logic [3:0]    sp_strb_q;
    logic [31:0]   sp_wd_q;
    logic [31:0]   sp_lo_q;
    logic [1:0]    sp_lane_q;
    logic [2:0]    sp_size_q;
    logic          sp_we_q;
`endif

    function automatic logic [31:0] extend(input logic [31:0] v, input logic [2:0] sz);
        case (sz)
            3'b000:  return {{24{v[7]}}, v[7:0]};
            3'b001:  return {{16{v[15]}}, v[15:0]};
            3'b100:  return {24'h0, v[7:0]};
            3'b101:  return {16'h0, v[15:0]};
            default: return v;
        endcase
    endfunction

    always_comb begin
        offset   = addr - BASE_ADDR;
        lane     = addr[1:0];
        shamt    = {lane, 3'b000};
        word_idx = offset[AW+1:2];
        nbytes   = 3'd4;
        mask     = 4'b1111;
        case (size[1:0])
            2'b00:   begin nbytes = 3'd1; mask = 4'b0001; end
            2'b01:   begin nbytes = 3'd2; mask = 4'b0011; end
            default: begin nbytes = 3'd4; mask = 4'b1111; end
        endcase
        // Range is checked on the last byte so a word-crossing access cannot run off the end.
        last_byte = {1'b0, offset} + 33'(nbytes - 3'd1);
        size_bad  = (size == 3'b011) || (size == 3'b110) || (size == 3'b111);
        store_bad = we && size[2];
        range_bad = last_byte >= SPAN;
`ifdef DMEM_MISALIGN_SPLIT_EN
        cross     = (3'(lane) + nbytes) > 3'd4;
        align_bad = 1'b0;
        strb8     = {4'b0000, mask} << lane;
        wd64      = {32'h0, wdata} << shamt;
        strb_lo   = strb8[3:0];
        wd_lo     = wd64[31:0];
`else
        align_bad = ((size[1:0] == 2'b01) && lane[0]) || ((size[1:0] == 2'b10) && (lane != 2'b00));
        strb_lo   = mask << lane;
        wd_lo     = wdata << shamt;
`endif
        acc_err   = size_bad || store_bad || range_bad || align_bad;
        accept    = req && ready && !reset;
        rd_word   = mem[word_idx];
    end

    always_ff @(posedge clk) begin
        if (accept && !acc_err && we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (strb_lo[i]) mem[word_idx][8*i +: 8] <= wd_lo[8*i +: 8];
            end
        end
`ifdef DMEM_MISALIGN_SPLIT_EN
        if (!reset && state_q == SPLIT) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (sp_strb_q[i]) mem[sp_idx_q][8*i +: 8] <= sp_wd_q[8*i +: 8];
            end
        end
`endif
    end

`ifdef DMEM_MISALIGN_SPLIT_EN
    // Low word is read and written at accept; the high half of the access is parked here for SPLIT.
    always_ff @(posedge clk) begin
        if (accept && !acc_err && cross) begin
            sp_idx_q  <= word_idx + AW'(1);
            sp_strb_q <= we ? strb8[7:4] : 4'b0000;
            sp_wd_q   <= wd64[63:32];
            sp_lo_q   <= rd_word;
            sp_lane_q <= lane;
            sp_size_q <= size;
            sp_we_q   <= we;
        end
    end
`endif

    always_comb begin
        state_d      = state_q;
        resp_valid_d = 1'b0;
        rdata_d      = '0;
        err_d        = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (acc_err) begin
                        resp_valid_d = 1'b1;
                        err_d        = 1'b1;
                    end
`ifdef DMEM_MISALIGN_SPLIT_EN
                    else if (cross) begin
                        state_d = SPLIT;
                    end
`endif
                    else begin
                        resp_valid_d = 1'b1;
                        if (!we) rdata_d = extend(rd_word >> shamt, size);
                    end
                end
            end
`ifdef DMEM_MISALIGN_SPLIT_EN
            SPLIT: begin
                state_d      = IDLE;
                resp_valid_d = 1'b1;
                if (!sp_we_q)
                    rdata_d = extend(32'({mem[sp_idx_q], sp_lo_q} >> {sp_lane_q, 3'b000}), sp_size_q);
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
        end
    end

    assign ready      = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign rdata      = rdata_q;
    assign err        = err_q;

endmodule

// File: tb/tb_data_mem_ls.sv
// Randomized and directed bench for data_mem_ls against a byte-array reference model.
`timescale 1ns/1ps
module tb_data_mem_ls;
    localparam int unsigned DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        reset, req, we;
    logic [31:0] addr, wdata, rdata;
    logic [2:0]  size;
    logic        ready, resp_valid, err;

    int n_vec = 0;
    int n_err = 0;
    byte unsigned mem_m [DEPTH*4];

    typedef struct {
        logic        w;
        logic [31:0] off;
        logic [2:0]  s;
        logic [31:0] d;
        logic [31:0] er;
        logic        ee;
    } vec_t;

    data_mem_ls #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .size(size),
        .wdata(wdata), .ready(ready), .resp_valid(resp_valid), .rdata(rdata), .err(err)
    );

    always #5 clk = ~clk;

    // Reference: memory as a flat byte array, RISC-V load/store rules applied directly.
    function automatic void model(input logic w, input logic [31:0] a, input logic [2:0] s,
                                  input logic [31:0] d, output logic e, output logic [31:0] rd,
                                  output int lat);
        longint off;
        longint v;
        int     nb;
        off = longint'({32'd0, a}) - longint'({32'd0, BASE});
        nb  = (s[1:0] == 2'b00) ? 1 : (s[1:0] == 2'b01) ? 2 : 4;
        v   = 0;
        rd  = 32'h0;
        e   = (s == 3'b011) || (s == 3'b110) || (s == 3'b111) || (w && s[2]) ||
              (off < 0) || (off + nb > DEPTH*4);
`ifndef DMEM_MISALIGN_SPLIT_EN
        if ((a % nb) != 0) e = 1'b1;
`endif
        lat = 1;
`ifdef DMEM_MISALIGN_SPLIT_EN
        if (!e && ((a % 4) + nb) > 4) lat = 2;
`endif
        if (!e) begin
            if (w) begin
                for (int i = 0; i < nb; i++) mem_m[off + i] = d[8*i +: 8];
            end else begin
                for (int i = 0; i < nb; i++) v = v + (longint'(mem_m[off + i]) << (8*i));
                if (!s[2] && nb < 4 && v[8*nb-1]) v = v - (longint'(1) << (8*nb));
                rd = v[31:0];
            end
        end
    endfunction

    // Called at a negedge; returns at the negedge where the response is visible.
    task automatic do_access(input logic w, input logic [31:0] a, input logic [2:0] s,
                             input logic [31:0] d, output logic [31:0] rd, output logic e,
                             output int lat, output int stall, output int busy);
        we = w; addr = a; size = s; wdata = d; req = 1'b1;
        stall = 0;
        while (ready !== 1'b1 && stall < 10) begin
            @(negedge clk);
            stall++;
        end
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        lat  = 1;
        busy = 0;
        while (resp_valid !== 1'b1 && lat < 10) begin
            if (ready !== 1'b1) busy++;
            @(negedge clk);
            lat++;
        end
        rd = rdata;
        e  = err;
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b exp 1", ready); end
        n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL reset_resp_valid got %b exp 0", resp_valid); end
        n_vec++; if (rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata got %h exp 0", rdata); end
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err got %b exp 0", err); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fill();
        logic [31:0] rd, mrd, d;
        logic        e, me;
        int          lat, stall, busy, mlat;
        for (int w = 0; w < DEPTH; w++) begin
            d = $urandom;
            model(1'b1, BASE + 32'(4*w), 3'b010, d, me, mrd, mlat);
            do_access(1'b1, BASE + 32'(4*w), 3'b010, d, rd, e, lat, stall, busy);
            n_vec++;
            if (e !== 1'b0 || lat !== 1) begin
                n_err++; $display("FAIL fill[%0d] err=%b lat=%0d exp err=0 lat=1", w, e, lat);
            end
        end
    endtask

    task automatic test_directed();
        vec_t        t[$];
        logic [31:0] rd, mrd, a;
        logic        e, me;
        int          lat, stall, busy, mlat;
        t.push_back('{1'b1, 32'h10, 3'b010, 32'hDEADBEEF, 32'h0, 1'b0});
        t.push_back('{1'b0, 32'h10, 3'b010, 32'h0, 32'hDEADBEEF, 1'b0});
        t.push_back('{1'b1, 32'h11, 3'b000, 32'h55, 32'h0, 1'b0});
        t.push_back('{1'b0, 32'h10, 3'b010, 32'h0, 32'hDEAD55EF, 1'b0});
        t.push_back('{1'b0, 32'h11, 3'b000, 32'h0, 32'h00000055, 1'b0});
        t.push_back('{1'b0, 32'h13, 3'b000, 32'h0, 32'hFFFFFFDE, 1'b0});
        t.push_back('{1'b0, 32'h13, 3'b100, 32'h0, 32'h000000DE, 1'b0});
        t.push_back('{1'b0, 32'h12, 3'b001, 32'h0, 32'hFFFFDEAD, 1'b0});
        t.push_back('{1'b0, 32'h12, 3'b101, 32'h0, 32'h0000DEAD, 1'b0});
        t.push_back('{1'b0, 32'(DEPTH*4), 3'b010, 32'h0, 32'h0, 1'b1});
        t.push_back('{1'b0, 32'h10, 3'b011, 32'h0, 32'h0, 1'b1});
        t.push_back('{1'b1, 32'h10, 3'b100, 32'hAA, 32'h0, 1'b1});
        t.push_back('{1'b0, 32'h10, 3'b010, 32'h0, 32'hDEAD55EF, 1'b0});
        t.push_back('{1'b0, 32'hFFFF_FFFF, 3'b000, 32'h0, 32'h0, 1'b1});
        t.push_back('{1'b1, 32'h10, 3'b001, 32'h1234CAFE, 32'h0, 1'b0});
        t.push_back('{1'b0, 32'h10, 3'b010, 32'h0, 32'hDEADCAFE, 1'b0});
`ifdef DMEM_MISALIGN_SPLIT_EN
        t.push_back('{1'b1, 32'h10, 3'b010, 32'h44332211, 32'h0, 1'b0});
        t.push_back('{1'b1, 32'h14, 3'b010, 32'h88776655, 32'h0, 1'b0});
        t.push_back('{1'b0, 32'h13, 3'b010, 32'h0, 32'h77665544, 1'b0});
        t.push_back('{1'b1, 32'h17, 3'b001, 32'hAABB, 32'h0, 1'b0});
        t.push_back('{1'b0, 32'h14, 3'b010, 32'h0, 32'hBB776655, 1'b0});
        t.push_back('{1'b0, 32'h18, 3'b100, 32'h0, 32'h000000AA, 1'b0});
        t.push_back('{1'b0, 32'h11, 3'b001, 32'h0, 32'h00003322, 1'b0});
        t.push_back('{1'b0, 32'(DEPTH*4-2), 3'b010, 32'h0, 32'h0, 1'b1});
`else
        t.push_back('{1'b0, 32'h11, 3'b010, 32'h0, 32'h0, 1'b1});
        t.push_back('{1'b1, 32'h13, 3'b001, 32'hBEEF, 32'h0, 1'b1});
        t.push_back('{1'b0, 32'h11, 3'b101, 32'h0, 32'h0, 1'b1});
        t.push_back('{1'b0, 32'h10, 3'b010, 32'h0, 32'hDEADCAFE, 1'b0});
`endif
        foreach (t[k]) begin
            a = BASE + t[k].off;
            model(t[k].w, a, t[k].s, t[k].d, me, mrd, mlat);
            do_access(t[k].w, a, t[k].s, t[k].d, rd, e, lat, stall, busy);
            n_vec++;
            if (rd !== t[k].er || e !== t[k].ee) begin
                n_err++; $display("FAIL directed[%0d] rdata=%h err=%b exp rdata=%h err=%b", k, rd, e, t[k].er, t[k].ee);
            end
            n_vec++;
            if (lat !== mlat || stall !== 0 || busy !== mlat - 1) begin
                n_err++; $display("FAIL directed_lat[%0d] lat=%0d stall=%0d busy=%0d exp lat=%0d", k, lat, stall, busy, mlat);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic        me;
        logic [31:0] mrd;
        int          mlat;
        model(1'b1, BASE + 32'h20, 3'b010, 32'h12345678, me, mrd, mlat);
        we = 1'b1; addr = BASE + 32'h20; size = 3'b010; wdata = 32'h12345678; req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (resp_valid !== 1'b1 || err !== 1'b0) begin
            n_err++; $display("FAIL b2b_store resp_valid=%b err=%b exp 1/0", resp_valid, err);
        end
        we = 1'b0; wdata = 32'h0;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        n_vec++;
        if (resp_valid !== 1'b1 || rdata !== 32'h12345678 || err !== 1'b0) begin
            n_err++; $display("FAIL b2b_load resp_valid=%b rdata=%h err=%b exp 1/12345678/0", resp_valid, rdata, err);
        end
        @(negedge clk);
        n_vec++;
        if (resp_valid !== 1'b0) begin
            n_err++; $display("FAIL b2b_pulse resp_valid=%b exp 0", resp_valid);
        end
    endtask

    task automatic test_reset_mid();
        we = 1'b0; addr = BASE + 32'h10; size = 3'b010; req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (resp_valid !== 1'b0 || rdata !== 32'h0 || err !== 1'b0 || ready !== 1'b1) begin
            n_err++; $display("FAIL reset_mid resp_valid=%b rdata=%h err=%b ready=%b exp 0/0/0/1",
                              resp_valid, rdata, err, ready);
        end
        reset = 1'b0; req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [31:0] rd, mrd, a, d;
        logic [2:0]  s;
        logic        w, e, me;
        int          lat, stall, busy, mlat;
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 5))
                0: s = 3'b000;
                1: s = 3'b001;
                2: s = 3'b010;
                3: s = 3'b100;
                4: s = 3'b101;
                default: s = 3'($urandom_range(0, 7));
            endcase
            w = ($urandom_range(0, 2) == 0);
            a = BASE - 32'd4 + 32'($urandom_range(0, DEPTH*4 + 8));
            d = $urandom;
            model(w, a, s, d, me, mrd, mlat);
            do_access(w, a, s, d, rd, e, lat, stall, busy);
            n_vec++;
            if (e !== me) begin
                n_err++; $display("FAIL rand_err[%0d] a=%h s=%b we=%b err=%b exp %b", n, a, s, w, e, me);
            end
            n_vec++;
            if (rd !== mrd) begin
                n_err++; $display("FAIL rand_rdata[%0d] a=%h s=%b we=%b rdata=%h exp %h", n, a, s, w, rd, mrd);
            end
            n_vec++;
            if (lat !== mlat || stall !== 0) begin
                n_err++; $display("FAIL rand_lat[%0d] a=%h lat=%0d stall=%0d exp lat=%0d", n, a, lat, stall, mlat);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; req = 1'b0; we = 1'b0; addr = '0; size = '0; wdata = '0;
        @(negedge clk);
        test_reset();
        test_fill();
        test_directed();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
